// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: FSM state
// encodings, baud-select width and the clocks-per-bit divisor table.
package uart_pkg;

  localparam int BAUD_SEL_W = 3;
  localparam int DIV_W      = 11;
  localparam int DATA_W     = 8;

  // Clocks per bit for each baud select value.
  localparam logic [DIV_W-1:0] DIV_SEL_000 = 11'd1042;
  localparam logic [DIV_W-1:0] DIV_SEL_001 = 11'd695;
  localparam logic [DIV_W-1:0] DIV_SEL_010 = 11'd521;
  localparam logic [DIV_W-1:0] DIV_SEL_011 = 11'd261;
  localparam logic [DIV_W-1:0] DIV_SEL_100 = 11'd174;
  localparam logic [DIV_W-1:0] DIV_SEL_101 = 11'd87;
  localparam logic [DIV_W-1:0] DIV_SEL_110 = 11'd79;
  localparam logic [DIV_W-1:0] DIV_SEL_111 = 11'd39;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    STOP_BIT   = 3'd3,
    CLEANUP    = 3'd4,
    PARITY_BIT = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_baud_sel.sv
// Combinational baud-select to clocks-per-bit lookup. Both ends of the
// link instantiate this so their bit periods come from one table.
module uart_baud_sel
  import uart_pkg::*;
#(
  parameter logic [DIV_W-1:0] CLKS_DEFAULT = DIV_SEL_000
) (
  input  logic [BAUD_SEL_W-1:0] sel_i,
  output logic [DIV_W-1:0]      div_o
);

  // Map the 3-bit select onto its divisor; anything unresolved falls back to 9600 baud.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    div_o = CLKS_DEFAULT;
    case (sel_i)
      3'b000:  div_o = DIV_SEL_000;
      3'b001:  div_o = DIV_SEL_001;
      3'b010:  div_o = DIV_SEL_010;
      3'b011:  div_o = DIV_SEL_011;
      3'b100:  div_o = DIV_SEL_100;
      3'b101:  div_o = DIV_SEL_101;
      3'b110:  div_o = DIV_SEL_110;
      3'b111:  div_o = DIV_SEL_111;
      default: div_o = CLKS_DEFAULT;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1: start bit, eight data bits LSB first, stop bit.
// Bit period comes from the shared baud-select table and is latched when a
// frame is accepted. One frame in flight; Tx_Start while busy is ignored.
// Build option UART_TX_PARITY_EN inserts an even-parity bit before the stop
// bit (frame grows from 10 to 11 bit periods).
module uart_tx
  import uart_pkg::*;
#(
  parameter logic [DIV_W-1:0] CLKS_DEFAULT = DIV_SEL_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BAUD_SEL_W-1:0] baud_rate_select,
  input  logic                  Tx_Start,
  input  logic [DATA_W-1:0]     Tx_Data,
  output logic                  Tx_Serial,
  output logic                  Tx_Busy,
  output logic                  Tx_Done
);

  uart_state_e       state_q;
  logic [DIV_W-1:0]  clk_count_q;
  logic [2:0]        bit_index_q;
  logic [DATA_W-1:0] data_q;
  logic [DIV_W-1:0]  div_q;
  logic              serial_q;
  logic              busy_q;
  logic              done_q;

  logic [DIV_W-1:0]  div_d;
  logic              bit_end;

  uart_baud_sel #(
    .CLKS_DEFAULT (CLKS_DEFAULT)
  ) u_baud_sel (
    .sel_i (baud_rate_select),
    .div_o (div_d)
  );

  // Last clock of the current bit period.
  assign bit_end = (clk_count_q == (div_q - 11'd1));

  // Transmit FSM; line, busy and done are all registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      state_q     <= IDLE;
      clk_count_q <= '0;
      bit_index_q <= '0;
      data_q      <= '0;
      div_q       <= DIV_SEL_000;
      serial_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          serial_q    <= 1'b1;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          clk_count_q <= '0;
          bit_index_q <= '0;
          if (Tx_Start) begin
            data_q   <= Tx_Data;
            div_q    <= div_d;
            serial_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= START_BIT;
          end
        end

        START_BIT: begin
          if (bit_end) begin
            serial_q    <= data_q[0];
            clk_count_q <= '0;
            bit_index_q <= '0;
            state_q     <= DATA_BITS;
          end else begin
            clk_count_q <= clk_count_q + 11'd1;
          end
        end

        DATA_BITS: begin
          if (bit_end) begin
            clk_count_q <= '0;
            if (bit_index_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              serial_q <= ^data_q;
              state_q  <= PARITY_BIT;
`else
              serial_q <= 1'b1;
              state_q  <= STOP_BIT;
`endif
            end else begin
              bit_index_q <= bit_index_q + 3'd1;
              serial_q    <= data_q[bit_index_q + 3'd1];
            end
          end else begin
            clk_count_q <= clk_count_q + 11'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY_BIT: begin
          if (bit_end) begin
            clk_count_q <= '0;
            serial_q    <= 1'b1;
            state_q     <= STOP_BIT;
          end else begin
            clk_count_q <= clk_count_q + 11'd1;
          end
        end
`endif

        STOP_BIT: begin
          if (bit_end) begin
            clk_count_q <= '0;
            done_q      <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= CLEANUP;
          end else begin
            clk_count_q <= clk_count_q + 11'd1;
          end
        end

        CLEANUP: begin
          clk_count_q <= '0;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end

        default: begin
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign Tx_Serial = serial_q;
  assign Tx_Busy   = busy_q;
  assign Tx_Done   = done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; companion to the UART receiver in the same protocol block.
- Serialises one byte as 8N1: start bit, 8 data bits LSB first, stop bit.
- Bit period is selected by the same 3-bit baud select and divisor table as the receiver.
- Sits between the host-side byte source and the Tx pin; one frame in flight at a time.

Parameters:
- CLKS_DEFAULT, 1042, divisor used for an undefined select value (9600 baud).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- baud_rate_select  input  3  divisor select: 000=1042, 001=695, 010=521, 011=261, 100=174, 101=87, 110=79, 111=39 clocks/bit
- Tx_Start  input  1  start request; sampled only in IDLE
- Tx_Data  input  8  byte to send; sampled with Tx_Start
- Tx_Serial  output  1  serial line, registered, idle high
- Tx_Busy  output  1  high while a frame is in progress
- Tx_Done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, rst=1), all registered:
  - Tx_Serial=1, Tx_Busy=0, Tx_Done=0.
  - State=IDLE, clk_count=0, bit_index=0, shift register=0, latched divisor=1042.
  - Reset mid-frame aborts immediately; the line returns high with no partial stop bit.
- Divisor B: 11-bit value taken from the table above.
  - Latched at frame accept; changes to baud_rate_select mid-frame have no effect.
  - clk_count is 11 bits and counts 0..B-1. Each bit lasts exactly B clocks.
- States:
  - IDLE: Tx_Serial=1, Tx_Busy=0. If Tx_Start=1 at edge E0: latch Tx_Data and B, Tx_Serial<=0, Tx_Busy<=1, clk_count<=0, go to TX_START_BIT.
  - TX_START_BIT: at clk_count==B-1, Tx_Serial<=data[0], clk_count<=0, bit_index<=0, go to TX_DATA_BITS. Otherwise increment clk_count.
  - TX_DATA_BITS: at clk_count==B-1, clk_count<=0.
    - If bit_index==7: Tx_Serial<=1 and go to TX_STOP_BIT.
    - Otherwise bit_index<=bit_index+1 and Tx_Serial<=data[bit_index+1].
  - TX_STOP_BIT: at clk_count==B-1, Tx_Done<=1, Tx_Busy<=1, go to CLEANUP.
  - CLEANUP: one clock. Tx_Done<=0, Tx_Busy<=0, go to IDLE.
  - Undefined encodings go to IDLE.
- Timing:
  - Start bit is visible after E0.
  - Tx_Done is high for the single cycle following edge E0+10B.
  - Earliest next accept is edge E0+10B+2, so the line stays high for at least B+1 clocks between frames.
- Tx_Start while Tx_Busy=1 is ignored (no queuing). Tx_Start held high continuously produces back-to-back frames at that minimum spacing.
- Tx_Data may change freely after the accept edge.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
  - Defined: state TX_PARITY_BIT is inserted between TX_DATA_BITS and TX_STOP_BIT. It drives the even-parity bit (XOR of the 8 latched bits) for B clocks. The frame becomes 11B clocks and Tx_Done moves to E0+11B.
  - Undefined: 8N1 exactly as above; no parity logic or state is present.

Decomposition:
- Package uart_pkg:
  - State encodings IDLE=0, START_BIT=1, DATA_BITS=2, STOP_BIT=3, CLEANUP=4, PARITY_BIT=5.
  - The eight 11-bit divisor constants and the baud-select width.
  - The receiver is migrated to the same package.
- Sub-module uart_baud_sel: combinational select→divisor lookup, shared with the receiver so both ends use identical tables.

Test Plan:
- Reset then idle: rst pulse, no Tx_Start for 100 clocks -> Tx_Serial=1, Tx_Busy=0, Tx_Done=0 throughout.
- Basic frame: select=111 (B=39), Tx_Data=0xA5, Tx_Start one cycle -> line 0 for 39 clks, then 1,0,1,0,0,1,0,1 each 39 clks, then 1 for 39 clks. Tx_Done pulse at clock 390, Tx_Busy low the cycle after.
- Busy ignore and select latch: during the 0x3C frame at select=101 (B=87), pulse Tx_Start with 0xFF and switch select to 000 -> 0x3C sent entirely at 87 clks/bit; no second frame.
- Back-to-back: Tx_Start held high, Tx_Data=0x00 then 0xFF, select=111 -> two frames, idle-high gap exactly 40 clocks, two Tx_Done pulses 392 clocks apart.
- Mid-frame reset: assert rst during bit 3 of 0x55 -> Tx_Serial=1 and Tx_Busy=0 immediately; a following 0x55 frame is sent correctly.
- Parity (UART_TX_PARITY_EN): 0x07, B=39 -> parity bit 1 for 39 clks before stop; Tx_Done at clock 429.
